amba_axi4_stream_rr_arbiter: RTL

Packet-level round-robin arbiter that shares one AXI4-Stream master (downstream) port among `N_SOURCES` AXI4-Stream slave (upstream) ports. A grant is locked from the first beat of a packet until the `TLAST` handshake, so packets are never interleaved. It sits between several stream producers and a single consumer, and the team's AXI4-Stream checkers are bound to both sides.

---
 rtl/amba_axi4_stream_rr_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/amba_axi4_stream_rr_arbiter.sv
// amba_axi4_stream_rr_arbiter: packet-locked round-robin mux of N AXI4-Stream sources onto one master.
// The grant is held from arbitration until the TLAST handshake; the data path is purely combinational.
module amba_axi4_stream_rr_arbiter #(
   parameter int N_SOURCES = 4,
   parameter int DATA_WIDTH_BYTES = 4,
   parameter int ID_WIDTH = 4,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 1,
   localparam int DW = DATA_WIDTH_BYTES * 8,
   localparam int GW = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1
) (
   input  logic                               ACLK,
   input  logic                               ARESET,
   input  logic [N_SOURCES*DW-1:0]            S_TDATA,
   input  logic [N_SOURCES*DATA_WIDTH_BYTES-1:0] S_TSTRB,
   input  logic [N_SOURCES*DATA_WIDTH_BYTES-1:0] S_TKEEP,
   input  logic [N_SOURCES-1:0]               S_TLAST,
   input  logic [N_SOURCES*ID_WIDTH-1:0]      S_TID,
   input  logic [N_SOURCES*DEST_WIDTH-1:0]    S_TDEST,
   input  logic [N_SOURCES*USER_WIDTH-1:0]    S_TUSER,
   input  logic [N_SOURCES-1:0]               S_TVALID,
   output logic [N_SOURCES-1:0]               S_TREADY,
   output logic [DW-1:0]                      M_TDATA,
   output logic [DATA_WIDTH_BYTES-1:0]        M_TSTRB,
   output logic [DATA_WIDTH_BYTES-1:0]        M_TKEEP,
   output logic                               M_TLAST,
   output logic [ID_WIDTH-1:0]                M_TID,
   output logic [DEST_WIDTH-1:0]              M_TDEST,
   output logic [USER_WIDTH-1:0]              M_TUSER,
   output logic                               M_TVALID,
   input  logic                               M_TREADY,
   output logic [GW-1:0]                      GRANT_IDX,
   output logic                               BUSY
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, state_nxt;
   logic [GW-1:0] grant, grant_nxt, prio, prio_nxt, sel;
   logic found, hs_last;
   // first requesting source at or after prio, wrapping modulo N_SOURCES
   always_comb begin
      sel = prio;
      found = 1'b0;
      for (int i = 0; i < N_SOURCES; i++) begin
         if (!found && S_TVALID[(int'(prio) + i) % N_SOURCES]) begin
            sel = GW'((int'(prio) + i) % N_SOURCES);
            found = 1'b1;
         end
      end
   end
   assign M_TDATA = S_TDATA[int'(grant)*DW +: DW];
   assign M_TSTRB = S_TSTRB[int'(grant)*DATA_WIDTH_BYTES +: DATA_WIDTH_BYTES];
   assign M_TKEEP = S_TKEEP[int'(grant)*DATA_WIDTH_BYTES +: DATA_WIDTH_BYTES];
   assign M_TLAST = S_TLAST[grant];
   assign M_TID = S_TID[int'(grant)*ID_WIDTH +: ID_WIDTH];
   assign M_TDEST = S_TDEST[int'(grant)*DEST_WIDTH +: DEST_WIDTH];
   assign M_TUSER = S_TUSER[int'(grant)*USER_WIDTH +: USER_WIDTH];
   assign M_TVALID = (state == LOCKED) && S_TVALID[grant];
   assign S_TREADY = (state == LOCKED) ? N_SOURCES'(M_TREADY) << grant : '0;
   assign hs_last = M_TVALID && M_TREADY && M_TLAST;
   assign BUSY = (state == LOCKED);
   assign GRANT_IDX = grant;
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      prio_nxt = prio;
      if (state == IDLE && found) begin
         state_nxt = LOCKED;
         grant_nxt = sel;
      end
      if (state == LOCKED && hs_last) begin
         state_nxt = IDLE;
         prio_nxt = (grant == GW'(N_SOURCES - 1)) ? '0 : grant + 1'b1;
      end
   end
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= IDLE;
         grant <= '0;
         prio <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         prio <= prio_nxt;
      end
   end
endmodule
